// File: rtl/wb_lbist_arb.sv
// wb_lbist_arb: two-master round-robin Wishbone arbiter.
// Master 0 is the management host, master 1 is the LBIST sequencer.
// A grant is held for the whole cyc of the winner, and ack/err/dat go back
// only to the granted master. With WB_ARB_TIMEOUT_EN defined, a stall
// counter aborts a beat after TO_CYCLES cycles without ack/err. In that case
// it raises a one-cycle err to the owner and drops s_stb_o for that cycle.
module wb_lbist_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state_reg, state_next;
    logic            last_gnt_reg, last_gnt_next;
    logic [1:0]      gnt_vec;
    logic            sel_cyc, sel_stb, sel_we;
    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_dat;
    logic [DW/8-1:0] sel_sel;
    logic            to_pulse;

    // Per-master response routing, indexed by master number
    logic [1:0]      m_ack, m_err;
    logic [DW-1:0]   m_dat [2];

    assign gnt_vec = {state_reg == GNT1, state_reg == GNT0};
    assign gnt_o   = gnt_vec;

    // State and round-robin history registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;   // master 0 wins the first tie
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // Next-state: arbitrate in IDLE, hold grant while the owner keeps cyc
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_next = last_gnt_reg ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_next = GNT0;
                else if (m1_cyc_i)
                    state_next = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request mux: the owner's signals pass straight through, and all are 0 when idle
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        sel_sel = '0;
        if (state_reg == GNT0) begin
            sel_cyc = m0_cyc_i;
            sel_stb = m0_stb_i;
            sel_we  = m0_we_i;
            sel_adr = m0_adr_i;
            sel_dat = m0_dat_i;
            sel_sel = m0_sel_i;
        end else if (state_reg == GNT1) begin
            sel_cyc = m1_cyc_i;
            sel_stb = m1_stb_i;
            sel_we  = m1_we_i;
            sel_adr = m1_adr_i;
            sel_dat = m1_dat_i;
            sel_sel = m1_sel_i;
        end
    end

    assign s_cyc_o = sel_cyc;
    assign s_stb_o = sel_stb & ~to_pulse;   // an aborted beat is withdrawn from the slave
    assign s_we_o  = sel_we;
    assign s_adr_o = sel_adr;
    assign s_dat_o = sel_dat;
    assign s_sel_o = sel_sel;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] to_cnt_reg, to_cnt_next;
    logic       stall;

    // The pulse fires on the TO_CYCLES-th consecutive stalled cycle, counting from 1
    assign stall    = (state_reg != IDLE) && sel_stb && !s_ack_i && !s_err_i;
    assign to_pulse = stall && (to_cnt_reg == TO_LAST);

    // Stall counter: count stalled beats and restart on ack/err/stb low/abort
    always_comb begin
        to_cnt_next = 8'd0;
        if (stall && !to_pulse)
            to_cnt_next = to_cnt_reg + 8'd1;
    end

    // Stall counter register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            to_cnt_reg <= 8'd0;
        else
            to_cnt_reg <= to_cnt_next;
    end
`else
    logic unused_to_cfg;
    assign unused_to_cfg = (TO_CYCLES != 0);
    assign to_pulse      = 1'b0;
`endif

    // Response routing: only the granted master sees ack/err/dat
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign m_ack[gi] = gnt_vec[gi] & s_ack_i;
        assign m_err[gi] = gnt_vec[gi] & (s_err_i | to_pulse);
        assign m_dat[gi] = gnt_vec[gi] ? s_dat_i : '0;
    end

    assign m0_ack_o = m_ack[0];
    assign m0_err_o = m_err[0];
    assign m0_dat_o = m_dat[0];
    assign m1_ack_o = m_ack[1];
    assign m1_err_o = m_err[1];
    assign m1_dat_o = m_dat[1];

endmodule

// File: tb/tb_wb_lbist_arb.sv
// Directed testbench for wb_lbist_arb (TO_CYCLES = 16).
// The timeout scenario follows WB_ARB_TIMEOUT_EN when the bench is built.
module tb_wb_lbist_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_adr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [DW-1:0]   m0_dat_o;
    logic            m0_ack_o, m0_err_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_adr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [DW-1:0]   m1_dat_o;
    logic            m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic [1:0]      gnt_o;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_lbist_arb #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    // Advance to 2ns after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [DW/8-1:0] sel);
        m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
        m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [DW/8-1:0] sel);
        m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
        m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        drive_m0(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 4'hF);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h3, 32'h4, 4'hF);
        s_ack_i = 1'b1; s_err_i = 1'b0; s_dat_i = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            total++;
            if (gnt_o !== 2'b00) begin
                bad++; $display("FAIL reset_gnt: got %b want 00", gnt_o);
            end
            total++;
            if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
                bad++; $display("FAIL reset_scyc: got cyc=%b stb=%b want 0/0", s_cyc_o, s_stb_o);
            end
            total++;
            if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin
                bad++; $display("FAIL reset_ack: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
            end
            total++;
            if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0 || s_adr_o !== 32'h0) begin
                bad++; $display("FAIL reset_dat: got m0=%h m1=%h adr=%h want 0", m0_dat_o, m1_dat_o, s_adr_o);
            end
        end
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        s_ack_i = 1'b0; s_dat_i = '0;
        wb_rst_i = 1'b0;
        step();
        $display("txn reset: done");
    endtask

    task automatic test_single_m0();
        drive_m0(1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'h0000_AB60, 4'hF);
        #1;
        total++;
        if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin
            bad++; $display("FAIL single_latency: got cyc=%b gnt=%b want 0/00", s_cyc_o, gnt_o);
        end
        step(); #1;
        total++;
        if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin
            bad++; $display("FAIL single_grant: got gnt=%b cyc=%b stb=%b we=%b want 01/1/1/1", gnt_o, s_cyc_o, s_stb_o, s_we_o);
        end
        total++;
        if (s_adr_o !== 32'h3000_0004 || s_dat_o !== 32'h0000_AB60 || s_sel_o !== 4'hF) begin
            bad++; $display("FAIL single_bus: got adr=%h dat=%h sel=%h want 30000004/0000ab60/f", s_adr_o, s_dat_o, s_sel_o);
        end
        s_ack_i = 1'b1;
        #1;
        total++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
            bad++; $display("FAIL single_ack: got m0_ack=%b m1_ack=%b m0_err=%b want 1/0/0", m0_ack_o, m1_ack_o, m0_err_o);
        end
        // Second beat ends in a slave error
        step();
        s_ack_i = 1'b0; s_err_i = 1'b1;
        #1;
        total++;
        if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
            bad++; $display("FAIL single_err: got m0_err=%b m0_ack=%b m1_err=%b want 1/0/0", m0_err_o, m0_ack_o, m1_err_o);
        end
        step();
        s_err_i = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        total++;
        if (gnt_o !== 2'b01) begin
            bad++; $display("FAIL single_hold: got %b want 01", gnt_o);
        end
        step(); #1;
        total++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            bad++; $display("FAIL single_release: got gnt=%b cyc=%b want 00/0", gnt_o, s_cyc_o);
        end
        $display("txn single_m0 write: gnt=%b", gnt_o);
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        // Fresh reset so master 0 wins the first tie
        wb_rst_i = 1'b1; step(); wb_rst_i = 1'b0;
        drive_m0(1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
        step(); #1;
        total++;
        if (gnt_o !== 2'b01) begin
            bad++; $display("FAIL rr_first: got %b want 01", gnt_o);
        end
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(); #1;
        total++;
        if (gnt_o !== 2'b00) begin
            bad++; $display("FAIL rr_idle_gap: got %b want 00", gnt_o);
        end
        step(); #1;
        total++;
        if (gnt_o !== 2'b10 || s_adr_o !== 32'h20) begin
            bad++; $display("FAIL rr_second: got gnt=%b adr=%h want 10/20", gnt_o, s_adr_o);
        end
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        // Four tie rounds: winners 0,1,0,1
        for (int r = 0; r < 4; r++) begin
            want = (r % 2 == 0) ? 2'b01 : 2'b10;
            drive_m0(1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF);
            drive_m1(1'b1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
            step(); #1;
            total++;
            if (gnt_o !== want) begin
                bad++; $display("FAIL rr_round%0d: got %b want %b", r, gnt_o, want);
            end
            $display("txn rr round %0d: gnt=%b", r, gnt_o);
            drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
            drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
            step();
        end
    endtask

    task automatic test_lock();
        drive_m1(1'b1, 1'b1, 1'b0, 32'h3000_0100, '0, 4'hF);
        step(); #1;
        total++;
        if (gnt_o !== 2'b10) begin
            bad++; $display("FAIL lock_grant: got %b want 10", gnt_o);
        end
        drive_m0(1'b1, 1'b1, 1'b1, 32'h3000_0200, 32'h1234, 4'h3);
        s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1;
            total++;
            if (gnt_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
                bad++; $display("FAIL lock_beat%0d: got gnt=%b m1_ack=%b m0_ack=%b want 10/1/0", b, gnt_o, m1_ack_o, m0_ack_o);
            end
            total++;
            if (m1_dat_o !== 32'hDEAD_BEEF || m0_dat_o !== 32'h0 || s_adr_o !== 32'h3000_0100) begin
                bad++; $display("FAIL lock_data%0d: got m1=%h m0=%h adr=%h want deadbeef/0/30000100", b, m1_dat_o, m0_dat_o, s_adr_o);
            end
            $display("txn lock beat %0d: m1_dat=%h", b, m1_dat_o);
            step();
        end
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(); #1;
        // Idle cycle: a stray slave ack must reach no one
        total++;
        if (gnt_o !== 2'b00 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            bad++; $display("FAIL lock_idle: got gnt=%b m0_ack=%b m1_ack=%b want 00/0/0", gnt_o, m0_ack_o, m1_ack_o);
        end
        step(); #1;
        total++;
        if (gnt_o !== 2'b01 || s_adr_o !== 32'h3000_0200 || m0_ack_o !== 1'b1) begin
            bad++; $display("FAIL lock_handover: got gnt=%b adr=%h ack=%b want 01/30000200/1", gnt_o, s_adr_o, m0_ack_o);
        end
        s_ack_i = 1'b0; s_dat_i = '0;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
    endtask

    task automatic test_timeout();
        int ncyc;
        int errs;
        logic want_err;
        ncyc = TO_ON ? 40 : 1000;
        errs = 0;
        drive_m0(1'b1, 1'b1, 1'b0, 32'h3000_0008, '0, 4'hF);
        step();
        for (int k = 1; k <= ncyc; k++) begin
            #1;
            want_err = TO_ON && (k % TO == 0);
            if (m0_err_o) errs++;
            total++;
            if (m0_err_o !== want_err || s_stb_o !== !want_err) begin
                bad++; $display("FAIL timeout_c%0d: got err=%b stb=%b want %b/%b", k, m0_err_o, s_stb_o, want_err, !want_err);
            end
            total++;
            if (m1_err_o !== 1'b0 || m1_ack_o !== 1'b0 || gnt_o !== 2'b01) begin
                bad++; $display("FAIL timeout_other_c%0d: got m1_err=%b m1_ack=%b gnt=%b want 0/0/01", k, m1_err_o, m1_ack_o, gnt_o);
            end
            step();
        end
        $display("txn timeout: %0d stall cycles, %0d err pulses", ncyc, errs);
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
    endtask

    task automatic test_reset_mid();
        drive_m1(1'b1, 1'b1, 1'b1, 32'h3000_0300, 32'h77, 4'hF);
        step(); #1;
        total++;
        if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1) begin
            bad++; $display("FAIL rstmid_grant: got gnt=%b cyc=%b want 10/1", gnt_o, s_cyc_o);
        end
        wb_rst_i = 1'b1;
        step();
        s_ack_i = 1'b1; s_err_i = 1'b1;
        #1;
        total++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_adr_o !== 32'h0) begin
            bad++; $display("FAIL rstmid_idle: got gnt=%b cyc=%b stb=%b adr=%h want 00/0/0/0", gnt_o, s_cyc_o, s_stb_o, s_adr_o);
        end
        total++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
            bad++; $display("FAIL rstmid_resp: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        wb_rst_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m0(1'b1, 1'b1, 1'b0, 32'h3000_0400, '0, 4'h1);
        step(); #1;
        total++;
        if (gnt_o !== 2'b01 || s_adr_o !== 32'h3000_0400 || s_sel_o !== 4'h1) begin
            bad++; $display("FAIL rstmid_after: got gnt=%b adr=%h sel=%h want 01/30000400/1", gnt_o, s_adr_o, s_sel_o);
        end
        $display("txn reset_mid: post-reset gnt=%b", gnt_o);
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        test_reset();
        test_single_m0();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
